tc_program_loader: RTL and testbench
====================================

TC_PROGRAM_LOADER -- requirements
Module: tc_program_loader

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, program word width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter BIT_DEPTH, default 256, number of words the target program memory holds.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  begin a load session at base_addr.
REQ-006 SHALL have port base_addr  input  16  first word address written in the session.
REQ-007 SHALL have port byte_valid  input  1  byte_data valid.
REQ-008 SHALL have port byte_data  input  8  next image byte.
REQ-009 SHALL have port byte_last  input  1  qualifies the final byte of the image.
REQ-010 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 SHALL have port wr_en  output  1  one-cycle word write strobe to program memory.
REQ-012 SHALL have port wr_addr  output  16  word address for wr_en.
REQ-013 SHALL have port wr_data  output  BIT_WIDTH  word for wr_en.
REQ-014 SHALL have port busy  output  1  session in progress.
REQ-015 SHALL have port done  output  1  session complete, held until next start.
REQ-016 SHALL have port overflow  output  1  sticky; bytes dropped past capacity.
REQ-017 SHALL have port word_count  output  16  words written this session.

Function
REQ-018 SHALL implement states IDLE, LOAD, DONE; start in IDLE or DONE -> LOAD, next cycle; start in LOAD ignored.
REQ-019 On entering LOAD SHALL clear done, overflow, word_count and the byte lane index, and load the write pointer with base_addr.
REQ-020 byte_ready SHALL equal (state == LOAD); a byte is accepted when byte_valid && byte_ready.
REQ-021 Bytes SHALL pack little-endian: first accepted byte of a word into [7:0], the next into [15:8], and so on up to BIT_WIDTH/8 bytes.
REQ-022 When the accepted byte completes a word, or carries byte_last, the loader SHALL assert wr_en for exactly one cycle on the following cycle, with wr_addr = pointer and wr_data = assembled word.
REQ-023 A partial final word SHALL be zero-padded in the unfilled upper bytes.
REQ-024 After each write the pointer SHALL increment by 1, wrapping 16'hFFFF -> 0, and word_count SHALL increment by 1.
REQ-025 Byte acceptance SHALL continue uninterrupted during the write cycle: full throughput is one byte per cycle with no back-pressure in LOAD.
REQ-026 When word_count == BIT_DEPTH, further completed words SHALL NOT be written; overflow SHALL set and stay set, and bytes are still accepted and discarded.
REQ-027 An accepted byte with byte_last SHALL move the FSM to DONE on the next cycle, concurrent with its wr_en if one is due; done = 1 and busy = 0 in DONE.
REQ-028 busy SHALL equal (state == LOAD).
REQ-029 byte_valid outside LOAD SHALL be ignored.

Reset
REQ-030 rst SHALL take priority over every input; on the next edge: state IDLE, byte_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, overflow 0, word_count 0, lane index 0.
REQ-031 rst asserted mid-session SHALL discard any partial word, and no wr_en SHALL occur for it.
REQ-032 The loader SHALL leave IDLE after reset only on start.

Verification
REQ-033 BIT_WIDTH=16, base 0x0010, bytes 11 22 33 44 (last on 44) -> wr 0x0010=0x2211, wr 0x0011=0x4433, word_count 2, done 1.
REQ-034 BIT_WIDTH=32, bytes AA BB CC (last on CC) -> single wr data 0x00CCBBAA; done next cycle.
REQ-035 BIT_DEPTH=2, BIT_WIDTH=8, bytes 01 02 03 04 (last on 04) -> writes only 01, 02; overflow 1; word_count 2; done 1.
REQ-036 base_addr 0xFFFF, BIT_WIDTH=8, bytes 5A A5 -> wr 0xFFFF=5A, then 0x0000=A5.
REQ-037 rst after 1 of 2 bytes of a 16-bit word -> no wr_en; all outputs 0; a fresh start reloads correctly.
REQ-038 Bytes gapped by byte_valid=0 cycles, plus start pulsed mid-LOAD -> packing unaffected and start ignored.

Source files
------------

// File: rtl/tc_program_loader.sv
// tc_program_loader: packs a little-endian byte stream into program-memory word writes.
module tc_program_loader #(
  parameter int BIT_WIDTH = 16,
  parameter int BIT_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          base_addr,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  input  logic                 byte_last,
  output logic                 byte_ready,
  output logic                 wr_en,
  output logic [15:0]          wr_addr,
  output logic [BIT_WIDTH-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [15:0]          word_count
);
  localparam int NB = BIT_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_n;
  logic [2:0] lane;
  logic [BIT_WIDTH-1:0] acc, word;
  logic [15:0] ptr;
  logic accept, enter, flush, full;
  assign byte_ready = state == LOAD;
  assign busy = state == LOAD;
  assign done = state == DONE;
  assign accept = byte_valid && byte_ready;
  assign enter = start && state != LOAD;
  assign flush = lane == 3'(NB - 1) || byte_last;
  assign full = word_count == 16'(BIT_DEPTH);
  // accumulator upper lanes are always zero, so a short final word is already padded
  assign word = acc | (BIT_WIDTH'(byte_data) << {lane, 3'b000});
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = enter ? LOAD : (accept && byte_last) ? DONE : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      lane       <= '0;
      acc        <= '0;
      ptr        <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_en <= 1'b0;
      if (enter) begin
        lane       <= '0;
        acc        <= '0;
        ptr        <= base_addr;
        word_count <= '0;
        overflow   <= 1'b0;
      end else if (accept && flush) begin
        lane <= '0;
        acc  <= '0;
        if (full) overflow <= 1'b1;
        else begin
          wr_en      <= 1'b1;
          wr_addr    <= ptr;
          wr_data    <= word;
          ptr        <= ptr + 16'd1;
          word_count <= word_count + 16'd1;
        end
      end else if (accept) begin
        lane <= lane + 3'd1;
        acc  <= word;
      end
    end
  end
endmodule

// File: tb/tb_tc_program_loader.sv
// tb_tc_program_loader: directed checks of three loader configurations sharing one byte stream.
module tb_tc_program_loader;
  logic clk = 0, rst = 1, start = 0, byte_valid = 0, byte_last = 0;
  logic [15:0] base_addr = 0;
  logic [7:0] byte_data = 0;
  logic br16, we16, bz16, dn16, ov16;
  logic [15:0] wa16, wc16, wd16;
  logic br32, we32, bz32, dn32, ov32;
  logic [15:0] wa32, wc32;
  logic [31:0] wd32;
  logic br8, we8, bz8, dn8, ov8;
  logic [15:0] wa8, wc8;
  logic [7:0] wd8;
  logic [79:0] q16[$], q32[$], q8[$];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  tc_program_loader #(.BIT_WIDTH(16), .BIT_DEPTH(256)) u16 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(br16), .wr_en(we16),
    .wr_addr(wa16), .wr_data(wd16), .busy(bz16), .done(dn16), .overflow(ov16), .word_count(wc16));
  tc_program_loader #(.BIT_WIDTH(32), .BIT_DEPTH(256)) u32 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(br32), .wr_en(we32),
    .wr_addr(wa32), .wr_data(wd32), .busy(bz32), .done(dn32), .overflow(ov32), .word_count(wc32));
  tc_program_loader #(.BIT_WIDTH(8), .BIT_DEPTH(2)) u8 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(br8), .wr_en(we8),
    .wr_addr(wa8), .wr_data(wd8), .busy(bz8), .done(dn8), .overflow(ov8), .word_count(wc8));

  always @(negedge clk) begin
    if (we16) q16.push_back({wa16, 64'(wd16)});
    if (we32) q32.push_back({wa32, 64'(wd32)});
    if (we8) q8.push_back({wa8, 64'(wd8)});
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic begin_load(input logic [15:0] a);
    q16.delete(); q32.delete(); q8.delete();
    start = 1; base_addr = a;
    tick(1);
    start = 0;
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    byte_valid = 1; byte_data = b; byte_last = l;
    tick(1);
    byte_valid = 0; byte_data = 0; byte_last = 0;
  endtask

  function automatic logic [79:0] ent(input logic [79:0] q[$], input int i);
    return q.size() > i ? q[i] : '1;
  endfunction

  initial begin
    tick(2);
    rst = 0;
    check("reset_outs", {br16, we16, wa16, wd16, bz16, dn16, ov16, wc16}, 0);
    tick(3);
    check("idle_hold", {bz16, dn16, br16}, 0);

    begin_load(16'h0010);
    check("load_busy", {bz16, br16, dn16}, 3'b110);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    check("t1_done", {dn16, bz16}, 2'b10);
    tick(2);
    check("t1_nwr", q16.size(), 2);
    check("t1_w0", ent(q16, 0), {16'h0010, 64'h2211});
    check("t1_w1", ent(q16, 1), {16'h0011, 64'h4433});
    check("t1_wc", wc16, 2);
    check("t1_w32", ent(q32, 0), {16'h0010, 64'h44332211});

    begin_load(16'h0000);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 1);
    check("t2_wr_now", {we32, dn32, wd32}, {2'b11, 32'h00CCBBAA});
    tick(2);
    check("t2_n32", q32.size(), 1);
    check("t2_pad16", ent(q16, 1), {16'h0001, 64'h00CC});
    check("t2_done_hold", dn32, 1);

    begin_load(16'h0000);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
    tick(2);
    check("t3_n8", q8.size(), 2);
    check("t3_w0", ent(q8, 0), {16'h0000, 64'h01});
    check("t3_w1", ent(q8, 1), {16'h0001, 64'h02});
    check("t3_flags", {ov8, dn8, wc8}, {2'b11, 16'd2});
    check("t3_noov16", ov16, 0);

    begin_load(16'hFFFF);
    check("t4_ovclr", ov8, 0);
    send(8'h5A, 0); send(8'hA5, 1);
    tick(2);
    check("t4_w0", ent(q8, 0), {16'hFFFF, 64'h5A});
    check("t4_w1", ent(q8, 1), {16'h0000, 64'hA5});
    check("t4_ov", ov8, 0);

    begin_load(16'h0030);
    send(8'h11, 0);
    rst = 1;
    tick(1);
    rst = 0;
    check("t5_rst_outs", {br16, we16, wa16, wd16, bz16, dn16, ov16, wc16}, 0);
    tick(2);
    check("t5_nowr", q16.size(), 0);
    begin_load(16'h0005);
    send(8'h77, 0); send(8'h88, 1);
    tick(2);
    check("t5_fresh", ent(q16, 0), {16'h0005, 64'h8877});
    check("t5_wc", wc16, 1);

    begin_load(16'h0020);
    send(8'h01, 0);
    tick(2);
    start = 1; base_addr = 16'h0099;
    send(8'h02, 0);
    start = 0;
    tick(1);
    check("t6_busy", {bz16, dn16}, 2'b10);
    send(8'h03, 0); send(8'h04, 1);
    tick(2);
    check("t6_w0", ent(q16, 0), {16'h0020, 64'h0201});
    check("t6_w1", ent(q16, 1), {16'h0021, 64'h0403});
    check("t6_wc", {wc16, dn16}, {16'd2, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
